// File: rtl/alu_issue_pkg.sv
// Shared types and constants for the ALU command issue stage.
package alu_issue_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_PAIR, WAIT_LAT} state_e;

  localparam int ENT_W = 8;
  localparam int ENT_N = 4;

  localparam logic [1:0]       LAT_STD     = 2'd1;
  localparam logic [1:0]       LAT_MUL     = 2'd3;
  localparam logic [ENT_N-1:0] MUL_CMD_A   = 4'd9;
  localparam logic [ENT_N-1:0] MUL_CMD_B   = 4'd10;
  localparam logic [4:0]       TIMEOUT_CYC = 5'd16;

  typedef struct packed {
    logic [ENT_W-1:0] opa;
    logic [ENT_W-1:0] opb;
    logic             cin;
    logic             mode;
    logic [ENT_N-1:0] cmd;
    logic [1:0]       inp_valid;
  } entry_t;

  // Multiplies in arithmetic mode take the long path through the ALU.
  function automatic logic [1:0] op_lat(input logic mode, input logic [ENT_N-1:0] cmd);
    return (mode && (cmd == MUL_CMD_A || cmd == MUL_CMD_B)) ? LAT_MUL : LAT_STD;
  endfunction
endpackage

// File: rtl/alu_issue_fifo.sv
// Small synchronous FIFO with async clear; head is visible combinationally.
module alu_issue_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          wr, rd;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign wr    = push & ~full;
  assign rd    = pop & ~empty;
  assign rdata = mem[rptr];

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr) wptr <= wptr + 1'b1;
      if (rd) rptr <= rptr + 1'b1;
      count <= count + {{AW{1'b0}}, wr} - {{AW{1'b0}}, rd};
    end

  always_ff @(posedge clk)
    if (wr) mem[wptr] <= wdata;
endmodule

// File: rtl/alu_cmd_issuer.sv
// ALU operand/command issue stage: buffers transactions and drives ALU ports.
// Optional pairing timeout enabled by defining ALU_ISSUE_TIMEOUT_EN.
module alu_cmd_issuer
  import alu_issue_pkg::*;
#(
  parameter int W     = ENT_W,
  parameter int N     = ENT_N,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     RST,
  input  logic                     CE,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [W-1:0]             in_opa,
  input  logic [W-1:0]             in_opb,
  input  logic                     in_cin,
  input  logic                     in_mode,
  input  logic [N-1:0]             in_cmd,
  input  logic [1:0]               in_inp_valid,
  output logic [W-1:0]             OPA,
  output logic [W-1:0]             OPB,
  output logic                     Cin,
  output logic                     mode,
  output logic [N-1:0]             CMD,
  output logic [1:0]               inp_valid,
  output logic                     res_expect,
  output logic                     timeout_err,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count
);
  state_e     state, state_nxt;
  entry_t     in_ent, head;
  logic       full, empty, push, pop, issue, slot, res_nxt;
  logic [1:0] lat_cnt, lat_nxt, iv_nxt;

  assign in_ent   = '{opa: in_opa, opb: in_opb, cin: in_cin, mode: in_mode,
                      cmd: in_cmd, inp_valid: in_inp_valid};
  assign in_ready = ~full & ~RST;
  assign push     = in_valid & in_ready;
  assign busy     = (state != IDLE);

  alu_issue_fifo #(.DW($bits(entry_t)), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(RST), .push(push), .pop(pop), .wdata(in_ent),
    .rdata(head), .full(full), .empty(empty), .count(fifo_count)
  );

`ifdef ALU_ISSUE_TIMEOUT_EN
  logic [4:0] tmr, tmr_nxt;
  logic       to_nxt;
`endif

  always_comb begin
    state_nxt = state;
    lat_nxt   = lat_cnt;
    iv_nxt    = inp_valid;
    pop       = 1'b0;
    issue     = 1'b0;
    slot      = 1'b0;
    res_nxt   = 1'b0;
`ifdef ALU_ISSUE_TIMEOUT_EN
    tmr_nxt   = tmr;
    to_nxt    = 1'b0;
`endif
    if (CE) begin
      case (state)
        IDLE: slot = 1'b1;
        WAIT_LAT:
          if (lat_cnt == 2'd1) begin
            res_nxt   = 1'b1;
            iv_nxt    = 2'b00;
            state_nxt = IDLE;
            slot      = 1'b1;
          end else lat_nxt = lat_cnt - 2'd1;
        WAIT_PAIR: begin
          if (!empty && (head.inp_valid == 2'b11 || head.inp_valid == ~inp_valid)) begin
            pop   = 1'b1;
            issue = 1'b1;
          end
`ifdef ALU_ISSUE_TIMEOUT_EN
          else begin
            tmr_nxt = tmr + 5'd1;
            if (tmr_nxt == TIMEOUT_CYC) begin
              to_nxt    = 1'b1;
              iv_nxt    = 2'b00;
              state_nxt = IDLE;
            end
          end
`endif
        end
        default: state_nxt = IDLE;
      endcase
      // An entry with no valid operands is consumed without touching the ALU.
      if (slot && !empty) begin
        pop   = 1'b1;
        issue = (head.inp_valid != 2'b00);
      end
      if (issue) begin
        iv_nxt = head.inp_valid;
        if (head.inp_valid == 2'b11 || state == WAIT_PAIR) begin
          state_nxt = WAIT_LAT;
          lat_nxt   = op_lat(head.mode, head.cmd);
        end else begin
          state_nxt = WAIT_PAIR;
`ifdef ALU_ISSUE_TIMEOUT_EN
          tmr_nxt   = '0;
`endif
        end
      end
    end
  end

  always_ff @(posedge clk or posedge RST)
    if (RST) begin
      state      <= IDLE;
      lat_cnt    <= '0;
      inp_valid  <= 2'b00;
      res_expect <= 1'b0;
      OPA        <= '0;
      OPB        <= '0;
      Cin        <= 1'b0;
      mode       <= 1'b0;
      CMD        <= '0;
    end else begin
      state      <= state_nxt;
      lat_cnt    <= lat_nxt;
      inp_valid  <= iv_nxt;
      res_expect <= res_nxt;
      if (issue) begin
        OPA  <= head.opa;
        OPB  <= head.opb;
        Cin  <= head.cin;
        mode <= head.mode;
        CMD  <= head.cmd;
      end
    end

`ifdef ALU_ISSUE_TIMEOUT_EN
  always_ff @(posedge clk or posedge RST)
    if (RST) begin
      tmr         <= '0;
      timeout_err <= 1'b0;
    end else begin
      tmr         <= tmr_nxt;
      timeout_err <= to_nxt;
    end
`else
  assign timeout_err = 1'b0;
`endif
endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Self-checking bench for alu_cmd_issuer: directed scenarios plus randomized traffic vs a queue model.
module tb_alu_cmd_issuer;
  localparam int W = 8, N = 4, DEPTH = 4;

  logic         clk = 1'b0, rst = 1'b0, ce = 1'b1, in_valid = 1'b0;
  logic         in_cin = 1'b0, in_mode = 1'b0;
  logic [W-1:0] in_opa = '0, in_opb = '0;
  logic [N-1:0] in_cmd = '0;
  logic [1:0]   in_iv = 2'b00;
  logic         in_ready, Cin, mode, res_expect, timeout_err, busy;
  logic [W-1:0] OPA, OPB;
  logic [N-1:0] CMD;
  logic [1:0]   inp_valid;
  logic [2:0]   fifo_count;

  int nchk = 0, nerr = 0;

  alu_cmd_issuer #(.W(W), .N(N), .DEPTH(DEPTH)) dut (
    .clk(clk), .RST(rst), .CE(ce), .in_valid(in_valid), .in_ready(in_ready),
    .in_opa(in_opa), .in_opb(in_opb), .in_cin(in_cin), .in_mode(in_mode),
    .in_cmd(in_cmd), .in_inp_valid(in_iv), .OPA(OPA), .OPB(OPB), .Cin(Cin),
    .mode(mode), .CMD(CMD), .inp_valid(inp_valid), .res_expect(res_expect),
    .timeout_err(timeout_err), .busy(busy), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference model: a transaction queue, a pending-result countdown and a pending-half record.
  typedef struct {
    logic [7:0] opa, opb;
    logic       cin, mode;
    logic [3:0] cmd;
    logic [1:0] iv;
  } ent_t;

  ent_t       m_q[$];
  logic [7:0] m_opa, m_opb;
  logic       m_cin, m_mode, m_res, m_to;
  logic [3:0] m_cmd;
  logic [1:0] m_iv, m_pair;
  int         m_lat, m_age;

  function automatic int lat_of(ent_t e);
    return (e.mode && (e.cmd == 4'd9 || e.cmd == 4'd10)) ? 3 : 1;
  endfunction

  task automatic m_reset();
    m_q.delete();
    m_opa = '0; m_opb = '0; m_cin = 0; m_mode = 0; m_cmd = '0; m_iv = 2'b00;
    m_res = 0; m_to = 0; m_pair = 2'b00; m_lat = 0; m_age = 0;
  endtask

  task automatic step();
    ent_t h, nw;
    bit   have, take, push_ok;
    push_ok = in_valid && !rst && (m_q.size() < DEPTH);
    nw = '{opa: in_opa, opb: in_opb, cin: in_cin, mode: in_mode, cmd: in_cmd, iv: in_iv};
    @(posedge clk);
    m_res = 0; m_to = 0;
    if (rst) m_reset();
    else begin
      if (ce) begin
        have = (m_q.size() > 0);
        if (have) h = m_q[0];
        take = 0;
        if (m_lat > 0) begin
          if (m_lat == 1) begin m_res = 1; m_iv = 2'b00; m_lat = 0; take = 1; end
          else m_lat--;
        end else if (m_pair != 2'b00) begin
          if (have && (h.iv == 2'b11 || h.iv == (2'b11 ^ m_pair))) begin
            void'(m_q.pop_front());
            m_opa = h.opa; m_opb = h.opb; m_cin = h.cin; m_mode = h.mode; m_cmd = h.cmd;
            m_iv = h.iv; m_pair = 2'b00; m_lat = lat_of(h);
          end else begin
            m_age++;
`ifdef ALU_ISSUE_TIMEOUT_EN
            if (m_age == 16) begin m_to = 1; m_iv = 2'b00; m_pair = 2'b00; end
`endif
          end
        end else take = 1;
        if (take && have) begin
          void'(m_q.pop_front());
          if (h.iv != 2'b00) begin
            m_opa = h.opa; m_opb = h.opb; m_cin = h.cin; m_mode = h.mode; m_cmd = h.cmd;
            m_iv = h.iv;
            if (h.iv == 2'b11) m_lat = lat_of(h);
            else begin m_pair = h.iv; m_age = 0; end
          end
        end
      end
      if (push_ok) m_q.push_back(nw);
    end
    #1;
  endtask

  task automatic set_in(input logic [1:0] iv, input logic md, input logic [3:0] cmd,
                        input logic [7:0] a, input logic [7:0] b);
    in_valid = 1; in_iv = iv; in_mode = md; in_cmd = cmd; in_opa = a; in_opb = b; in_cin = 0;
  endtask

  task automatic idle(input int n);
    in_valid = 0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    rst = 1; m_reset(); #1;
    nchk++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL rst_ready got %b want 0", in_ready); end
    nchk++; if ({OPA, OPB, Cin, mode, CMD} !== '0) begin nerr++; $display("FAIL rst_ports got %h/%h/%b/%b/%h want 0", OPA, OPB, Cin, mode, CMD); end
    nchk++; if ({inp_valid, res_expect, timeout_err, busy} !== 5'b0) begin nerr++; $display("FAIL rst_ctl got iv=%b res=%b to=%b busy=%b want 0", inp_valid, res_expect, timeout_err, busy); end
    nchk++; if (fifo_count !== 3'd0) begin nerr++; $display("FAIL rst_count got %0d want 0", fifo_count); end
    step(); step();
    rst = 0; #1;
    nchk++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL rst_release_ready got %b want 1", in_ready); end
  endtask

  task automatic test_add();
    idle(2);
    set_in(2'b11, 1, 4'd0, 8'h05, 8'h03); step(); in_valid = 0;
    nchk++; if (fifo_count !== 3'd1 || inp_valid !== 2'b00) begin nerr++; $display("FAIL add_push got cnt=%0d iv=%b want 1/00", fifo_count, inp_valid); end
    step();
    nchk++; if (inp_valid !== 2'b11 || OPA !== 8'h05 || OPB !== 8'h03 || CMD !== 4'd0 || mode !== 1'b1) begin nerr++; $display("FAIL add_issue got iv=%b a=%h b=%h cmd=%h m=%b want 11/05/03/0/1", inp_valid, OPA, OPB, CMD, mode); end
    nchk++; if (res_expect !== 1'b0 || busy !== 1'b1) begin nerr++; $display("FAIL add_wait got res=%b busy=%b want 0/1", res_expect, busy); end
    step();
    nchk++; if (res_expect !== 1'b1 || inp_valid !== 2'b00 || busy !== 1'b0) begin nerr++; $display("FAIL add_res got res=%b iv=%b busy=%b want 1/00/0", res_expect, inp_valid, busy); end
    step();
    nchk++; if (res_expect !== 1'b0) begin nerr++; $display("FAIL add_pulse got res=%b want 0", res_expect); end
  endtask

  task automatic test_back_to_back();
    idle(2);
    set_in(2'b11, 1, 4'd9, 8'h12, 8'h34); step();
    set_in(2'b11, 1, 4'd0, 8'h56, 8'h78); step(); in_valid = 0;
    nchk++; if (CMD !== 4'd9 || inp_valid !== 2'b11) begin nerr++; $display("FAIL mul_issue got cmd=%0d iv=%b want 9/11", CMD, inp_valid); end
    for (int k = 1; k <= 2; k++) begin
      step();
      nchk++; if (res_expect !== 1'b0 || CMD !== 4'd9) begin nerr++; $display("FAIL mul_wait%0d got res=%b cmd=%0d want 0/9", k, res_expect, CMD); end
    end
    step();
    nchk++; if (res_expect !== 1'b1 || CMD !== 4'd0 || OPA !== 8'h56 || inp_valid !== 2'b11) begin nerr++; $display("FAIL mul_res_add_issue got res=%b cmd=%0d a=%h iv=%b want 1/0/56/11", res_expect, CMD, OPA, inp_valid); end
    step();
    nchk++; if (res_expect !== 1'b1 || inp_valid !== 2'b00) begin nerr++; $display("FAIL add_after_mul got res=%b iv=%b want 1/00", res_expect, inp_valid); end
  endtask

  task automatic test_pair();
    idle(2);
    set_in(2'b01, 0, 4'd1, 8'hAA, 8'h00); step(); in_valid = 0;
    step();
    nchk++; if (inp_valid !== 2'b01 || OPA !== 8'hAA || busy !== 1'b1) begin nerr++; $display("FAIL pair_first got iv=%b a=%h busy=%b want 01/AA/1", inp_valid, OPA, busy); end
    for (int k = 0; k < 3; k++) begin
      step();
      nchk++; if (inp_valid !== 2'b01 || timeout_err !== 1'b0) begin nerr++; $display("FAIL pair_hold got iv=%b to=%b want 01/0", inp_valid, timeout_err); end
    end
    set_in(2'b10, 0, 4'd1, 8'h00, 8'h55); step(); in_valid = 0;
    step();
    nchk++; if (inp_valid !== 2'b10 || OPB !== 8'h55 || res_expect !== 1'b0) begin nerr++; $display("FAIL pair_second got iv=%b b=%h res=%b want 10/55/0", inp_valid, OPB, res_expect); end
    step();
    nchk++; if (res_expect !== 1'b1 || inp_valid !== 2'b00 || timeout_err !== 1'b0) begin nerr++; $display("FAIL pair_res got res=%b iv=%b to=%b want 1/00/0", res_expect, inp_valid, timeout_err); end
  endtask

  task automatic test_full_ce();
    idle(2);
    ce = 0;
    for (int i = 0; i < 4; i++) begin set_in(2'b11, 0, 4'(i + 1), 8'(16 * i + 1), 8'h10); step(); end
    nchk++; if (in_ready !== 1'b0 || fifo_count !== 3'd4) begin nerr++; $display("FAIL full_state got rdy=%b cnt=%0d want 0/4", in_ready, fifo_count); end
    set_in(2'b11, 0, 4'd7, 8'hEE, 8'hEE); step(); in_valid = 0;
    nchk++; if (fifo_count !== 3'd4 || inp_valid !== 2'b00) begin nerr++; $display("FAIL full_nopush got cnt=%0d iv=%b want 4/00", fifo_count, inp_valid); end
    ce = 1; step();
    nchk++; if (fifo_count !== 3'd3 || in_ready !== 1'b1 || OPA !== 8'h01) begin nerr++; $display("FAIL full_resume got cnt=%0d rdy=%b a=%h want 3/1/01", fifo_count, in_ready, OPA); end
    for (int k = 0; k < 5; k++) begin
      step();
      nchk++; if (OPA !== m_opa || inp_valid !== m_iv || res_expect !== m_res) begin nerr++; $display("FAIL full_drain%0d got a=%h iv=%b res=%b want %h/%b/%b", k, OPA, inp_valid, res_expect, m_opa, m_iv, m_res); end
    end
  endtask

  task automatic test_reset_mid_lat();
    idle(2);
    set_in(2'b11, 1, 4'd9, 8'h77, 8'h66); step(); in_valid = 0;
    step(); step();
    rst = 1; m_reset(); #1;
    nchk++; if ({OPA, OPB, CMD, mode, inp_valid, busy, in_ready} !== '0 || fifo_count !== 3'd0) begin nerr++; $display("FAIL midrst got a=%h b=%h cmd=%h m=%b iv=%b busy=%b rdy=%b cnt=%0d want 0", OPA, OPB, CMD, mode, inp_valid, busy, in_ready, fifo_count); end
    step();
    rst = 0; #1;
    nchk++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL midrst_ready got %b want 1", in_ready); end
    for (int k = 0; k < 4; k++) begin
      step();
      nchk++; if (res_expect !== 1'b0 || busy !== 1'b0) begin nerr++; $display("FAIL midrst_nores got res=%b busy=%b want 0/0", res_expect, busy); end
    end
  endtask

  task automatic test_timeout();
    logic exp_to;
    idle(2);
    set_in(2'b01, 0, 4'd2, 8'h3C, 8'h00); step(); in_valid = 0;
    step();
    nchk++; if (inp_valid !== 2'b01) begin nerr++; $display("FAIL to_issue got iv=%b want 01", inp_valid); end
`ifdef ALU_ISSUE_TIMEOUT_EN
    for (int k = 1; k <= 16; k++) begin
      step();
      exp_to = (k == 16);
      nchk++; if (timeout_err !== exp_to) begin nerr++; $display("FAIL to_pulse cyc%0d got %b want %b", k, timeout_err, exp_to); end
    end
    nchk++; if (inp_valid !== 2'b00 || busy !== 1'b0) begin nerr++; $display("FAIL to_after got iv=%b busy=%b want 00/0", inp_valid, busy); end
    step();
    nchk++; if (timeout_err !== 1'b0) begin nerr++; $display("FAIL to_width got %b want 0", timeout_err); end
`else
    for (int k = 1; k <= 20; k++) begin
      step();
      exp_to = 1'b0;
      nchk++; if (timeout_err !== exp_to) begin nerr++; $display("FAIL to_tied cyc%0d got %b want 0", k, timeout_err); end
    end
    nchk++; if (inp_valid !== 2'b01 || busy !== 1'b1) begin nerr++; $display("FAIL to_wait got iv=%b busy=%b want 01/1", inp_valid, busy); end
`endif
    rst = 1; m_reset(); step(); rst = 0;
  endtask

  task automatic test_random();
    int r;
    for (int it = 0; it < 600; it++) begin
      rst = ($urandom_range(0, 99) < 2);
      if (rst) m_reset();
      ce = ($urandom_range(0, 9) < 8);
      in_valid = $urandom_range(0, 1);
      r = $urandom_range(0, 9);
      in_iv = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : (r == 2) ? 2'b10 : 2'b11;
      in_mode = $urandom_range(0, 1);
      in_cmd = ($urandom_range(0, 2) == 0) ? 4'(9 + $urandom_range(0, 1)) : 4'($urandom_range(0, 15));
      in_opa = 8'($urandom); in_opb = 8'($urandom); in_cin = $urandom_range(0, 1);
      step();
      nchk++; if (OPA !== m_opa || OPB !== m_opb) begin nerr++; $display("FAIL rnd%0d_ops got %h/%h want %h/%h", it, OPA, OPB, m_opa, m_opb); end
      nchk++; if (Cin !== m_cin || mode !== m_mode || CMD !== m_cmd) begin nerr++; $display("FAIL rnd%0d_ctl got %b/%b/%h want %b/%b/%h", it, Cin, mode, CMD, m_cin, m_mode, m_cmd); end
      nchk++; if (inp_valid !== m_iv) begin nerr++; $display("FAIL rnd%0d_iv got %b want %b", it, inp_valid, m_iv); end
      nchk++; if (res_expect !== m_res || timeout_err !== m_to) begin nerr++; $display("FAIL rnd%0d_pulse got res=%b to=%b want %b/%b", it, res_expect, timeout_err, m_res, m_to); end
      nchk++; if (busy !== ((m_lat > 0) || (m_pair != 2'b00))) begin nerr++; $display("FAIL rnd%0d_busy got %b want %b", it, busy, (m_lat > 0) || (m_pair != 2'b00)); end
      nchk++; if (fifo_count !== 3'(m_q.size()) || in_ready !== ((m_q.size() < DEPTH) && !rst)) begin nerr++; $display("FAIL rnd%0d_fifo got cnt=%0d rdy=%b want %0d/%b", it, fifo_count, in_ready, m_q.size(), (m_q.size() < DEPTH) && !rst); end
    end
    rst = 0;
  endtask

  initial begin
    m_reset();
    #2;
    test_reset();
    test_add();
    test_back_to_back();
    test_pair();
    test_full_ce();
    test_reset_mid_lat();
    test_timeout();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
    $finish;
  end
endmodule
